banked_reg_bank: RTL and testbench

Parametrised, single-clock successor register bank for the ARMAria core. It holds a general register file of configurable depth and width, plus per-mode banked stack pointers. User/kernel mode switching is sequenced by a small state machine, and a `busy` stall handshake is raised during switches. Read-after-write bypass is optional. The block sits between decode/ALU/memory stages and the PC/SP consumers, and replaces the fixed 16×32 bank.

---
 rtl/armaria_regbank_pkg.sv | 20 ++
 rtl/regbank_mode_fsm.sv | 79 +++++++
 rtl/banked_reg_bank.sv | 151 +++++++++++++++
 tb/tb_banked_reg_bank.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/armaria_regbank_pkg.sv
// Shared types for the ARMAria banked register bank: control op codes and mode FSM states.
package armaria_regbank_pkg;

   typedef enum logic [2:0] {
      OP_SP    = 3'd0,
      OP_ALU   = 3'd1,
      OP_MEM   = 3'd3,
      OP_ENTER = 3'd4,
      OP_EXIT  = 3'd5,
      OP_CPXR  = 3'd6
   } op_e;

   typedef enum logic [1:0] {
      USER     = 2'd0,
      ENTERING = 2'd1,
      KERNEL   = 2'd2,
      EXITING  = 2'd3
   } mode_e;

endpackage

// File: rtl/regbank_mode_fsm.sv
// User/kernel mode sequencer: owns the mode state, registered busy/privileged and the
// combinational strobes that move stack pointers between the bank and the shadows.
//
// state    | meaning
// USER     | unprivileged, ops accepted
// ENTERING | switching in; kernel SP is loaded on leaving
// KERNEL   | privileged, ops accepted
// EXITING  | switching out; user SP is loaded on leaving
module regbank_mode_fsm
   import armaria_regbank_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       op_valid_i,
   input  logic [2:0] control_i,
   output logic       busy_o,
   output logic       privileged_o,
   output logic       save_user_sp_o,
   output logic       load_kernel_sp_o,
   output logic       save_kernel_sp_o,
   output logic       load_user_sp_o,
   output logic       save_lr_o
);

   mode_e state_q;
   logic  busy_q;
   logic  privileged_q;
   logic  enter_req;
   logic  exit_req;

   assign enter_req = op_valid_i && (control_i == OP_ENTER);
   assign exit_req  = op_valid_i && (control_i == OP_EXIT);

   assign save_user_sp_o   = (state_q == USER) && enter_req;
   assign save_lr_o        = (state_q == USER) && enter_req;
   assign load_kernel_sp_o = (state_q == ENTERING);
   assign save_kernel_sp_o = (state_q == KERNEL) && exit_req;
   assign load_user_sp_o   = (state_q == EXITING);

   assign busy_o       = busy_q;
   assign privileged_o = privileged_q;

   // busy spans the transient state plus the first stable cycle, so that the
   // stall lifts only once the new-mode SP is visible on current_SP.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= USER;
         busy_q       <= 1'b0;
         privileged_q <= 1'b0;
      end else begin
         case (state_q)
            USER: begin
               busy_q <= enter_req;
               if (enter_req) state_q <= ENTERING;
            end
            ENTERING: begin
               state_q      <= KERNEL;
               busy_q       <= 1'b1;
               privileged_q <= 1'b1;
            end
            KERNEL: begin
               busy_q <= exit_req;
               if (exit_req) state_q <= EXITING;
            end
            EXITING: begin
               state_q      <= USER;
               busy_q       <= 1'b1;
               privileged_q <= 1'b0;
            end
            default: begin
               state_q      <= USER;
               busy_q       <= 1'b0;
               privileged_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/banked_reg_bank.sv
// Parametrised register bank with banked user/kernel stack pointers and registered read ports.
// Define REGBANK_BYPASS_EN to forward same-cycle writes to every read port.
module banked_reg_bank
   import armaria_regbank_pkg::*;
#(
   parameter int REGISTER_LENGTH = 32,
   parameter int NUM_REGS        = 16,
   parameter int PC_REGISTER     = 15,
   parameter int SP_REGISTER     = 14,
   parameter int LR_REGISTER     = 13,
   parameter int PC_RESET        = 1,
   parameter int DATA_AREA_START = 8192,
   parameter int USER_STACK      = 8191,
   parameter int KERNEL_STACK    = 6143,
   parameter int SPECREG_LENGTH  = 4
) (
   input  logic                          slow_clock_i,
   input  logic                          reset_i,
   input  logic                          enable_i,
   input  logic                          should_branch_i,
   input  logic [2:0]                    control_i,
   input  logic [$clog2(NUM_REGS)-1:0]   register_source_A_i,
   input  logic [$clog2(NUM_REGS)-1:0]   register_source_B_i,
   input  logic [$clog2(NUM_REGS)-1:0]   register_Dest_i,
   input  logic [REGISTER_LENGTH-1:0]    ALU_result_i,
   input  logic [REGISTER_LENGTH-1:0]    data_from_memory_i,
   input  logic [REGISTER_LENGTH-1:0]    new_SP_i,
   input  logic [REGISTER_LENGTH-1:0]    new_PC_i,
   input  logic [SPECREG_LENGTH-1:0]     special_register_i,
   output logic [REGISTER_LENGTH-1:0]    read_data_A_o,
   output logic [REGISTER_LENGTH-1:0]    read_data_B_o,
   output logic [REGISTER_LENGTH-1:0]    memory_output_o,
   output logic [REGISTER_LENGTH-1:0]    current_PC_o,
   output logic [REGISTER_LENGTH-1:0]    current_SP_o,
   output logic                          privileged_o,
   output logic                          busy_o
);

   localparam int RA = $clog2(NUM_REGS);
   localparam logic [RA-1:0] PC_IDX     = RA'(PC_REGISTER);
   localparam logic [RA-1:0] SP_IDX     = RA'(SP_REGISTER);
   localparam logic [RA-1:0] LR_IDX     = RA'(LR_REGISTER);
   localparam logic [RA:0]   NUM_REGS_W = (RA+1)'(NUM_REGS);

   logic [REGISTER_LENGTH-1:0] regs_q [NUM_REGS];
   logic [REGISTER_LENGTH-1:0] regs_d [NUM_REGS];
   logic [REGISTER_LENGTH-1:0] rd_src [NUM_REGS];
   logic [REGISTER_LENGTH-1:0] user_sp_q, user_sp_d;
   logic [REGISTER_LENGTH-1:0] kernel_sp_q, kernel_sp_d;
   logic [REGISTER_LENGTH-1:0] rd_a_q, rd_b_q, mem_out_q, cur_pc_q, cur_sp_q;
   logic [REGISTER_LENGTH-1:0] spec_ext;

   logic busy;
   logic accept;
   logic dest_ok, a_ok, b_ok;
   logic save_user_sp, load_kernel_sp, save_kernel_sp, load_user_sp, save_lr;
   op_e  op;

   assign accept   = enable_i && !busy;
   assign op       = op_e'(control_i);
   assign dest_ok  = {1'b0, register_Dest_i} < NUM_REGS_W;
   assign a_ok     = {1'b0, register_source_A_i} < NUM_REGS_W;
   assign b_ok     = {1'b0, register_source_B_i} < NUM_REGS_W;
   assign spec_ext = {{(REGISTER_LENGTH-SPECREG_LENGTH){1'b0}}, special_register_i};

   regbank_mode_fsm u_mode_fsm (
      .clk_i            (slow_clock_i),
      .rst_i            (reset_i),
      .op_valid_i       (accept),
      .control_i        (control_i),
      .busy_o           (busy),
      .privileged_o     (privileged_o),
      .save_user_sp_o   (save_user_sp),
      .load_kernel_sp_o (load_kernel_sp),
      .save_kernel_sp_o (save_kernel_sp),
      .load_user_sp_o   (load_user_sp),
      .save_lr_o        (save_lr)
   );

   assign busy_o = busy;

   always_comb begin
      regs_d      = regs_q;
      user_sp_d   = user_sp_q;
      kernel_sp_d = kernel_sp_q;
      if (load_kernel_sp) regs_d[SP_IDX] = kernel_sp_q;
      if (load_user_sp)   regs_d[SP_IDX] = user_sp_q;
      if (accept) begin
         regs_d[PC_IDX] = should_branch_i ? ALU_result_i : new_PC_i;
         case (op)
            OP_ALU: begin
               if (dest_ok && register_Dest_i != PC_IDX && register_Dest_i != SP_IDX)
                  regs_d[register_Dest_i] = ALU_result_i;
            end
            OP_MEM: begin
               if (dest_ok && register_Dest_i != PC_IDX && register_Dest_i != SP_IDX)
                  regs_d[register_Dest_i] = data_from_memory_i;
               regs_d[SP_IDX] = new_SP_i;
            end
            OP_ENTER, OP_EXIT: ;
            OP_CPXR: begin
               if (dest_ok && register_Dest_i != PC_IDX)
                  regs_d[register_Dest_i] = spec_ext;
            end
            default: regs_d[SP_IDX] = new_SP_i;
         endcase
         // LR captures the PC as it was before this edge's PC update.
         if (save_lr) regs_d[LR_IDX] = regs_q[PC_IDX];
      end
      if (save_user_sp)   user_sp_d   = regs_q[SP_IDX];
      if (save_kernel_sp) kernel_sp_d = regs_q[SP_IDX];
   end

`ifdef REGBANK_BYPASS_EN
   always_comb rd_src = regs_d;
`else
   always_comb rd_src = regs_q;
`endif

   always_ff @(posedge slow_clock_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
         regs_q[0]      <= REGISTER_LENGTH'(DATA_AREA_START);
         regs_q[SP_IDX] <= REGISTER_LENGTH'(USER_STACK);
         regs_q[PC_IDX] <= REGISTER_LENGTH'(PC_RESET);
         user_sp_q      <= '0;
         kernel_sp_q    <= REGISTER_LENGTH'(KERNEL_STACK);
         rd_a_q         <= '0;
         rd_b_q         <= '0;
         mem_out_q      <= '0;
         cur_pc_q       <= REGISTER_LENGTH'(PC_RESET);
         cur_sp_q       <= REGISTER_LENGTH'(USER_STACK);
      end else begin
         regs_q      <= regs_d;
         user_sp_q   <= user_sp_d;
         kernel_sp_q <= kernel_sp_d;
         rd_a_q      <= a_ok ? rd_src[register_source_A_i] : '0;
         rd_b_q      <= b_ok ? rd_src[register_source_B_i] : '0;
         mem_out_q   <= dest_ok ? rd_src[register_Dest_i] : '0;
         cur_pc_q    <= rd_src[PC_IDX];
         cur_sp_q    <= rd_src[SP_IDX];
      end
   end

   assign read_data_A_o   = rd_a_q;
   assign read_data_B_o   = rd_b_q;
   assign memory_output_o = mem_out_q;
   assign current_PC_o    = cur_pc_q;
   assign current_SP_o    = cur_sp_q;

endmodule

// File: tb/tb_banked_reg_bank.sv
// Self-checking bench for banked_reg_bank: directed mode-switch scenarios plus random ops
// compared every cycle against an array-based reference model.
module tb_banked_reg_bank;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en  = 1'b0;
   logic        br  = 1'b0;
   logic [2:0]  ctl = 3'd0;
   logic [3:0]  ra  = 4'd0, rb = 4'd0, rd = 4'd0;
   logic [31:0] alu = '0, mem = '0, nsp = '0, npc = '0;
   logic [3:0]  spec = 4'd0;

   logic [31:0] rda, rdb, mo, cpc, csp;
   logic        priv, busy;

   int checks = 0;
   int errors = 0;

   banked_reg_bank dut (
      .slow_clock_i        (clk),
      .reset_i             (rst),
      .enable_i            (en),
      .should_branch_i     (br),
      .control_i           (ctl),
      .register_source_A_i (ra),
      .register_source_B_i (rb),
      .register_Dest_i     (rd),
      .ALU_result_i        (alu),
      .data_from_memory_i  (mem),
      .new_SP_i            (nsp),
      .new_PC_i            (npc),
      .special_register_i  (spec),
      .read_data_A_o       (rda),
      .read_data_B_o       (rdb),
      .memory_output_o     (mo),
      .current_PC_o        (cpc),
      .current_SP_o        (csp),
      .privileged_o        (priv),
      .busy_o              (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", tag, act, exp);
      end
   endtask

   // Reference model: architectural registers, SP shadows, and a switch countdown.
   logic [31:0] m_r [16];
   logic [31:0] m_usp, m_ksp;
   int          m_phase;
   bit          m_entering, m_kernel, m_priv, m_busy;
   logic [31:0] e_rda, e_rdb, e_mo, e_cpc, e_csp;

   task automatic m_reset();
      for (int i = 0; i < 16; i++) m_r[i] = '0;
      m_r[0]  = 32'd8192;
      m_r[14] = 32'd8191;
      m_r[15] = 32'd1;
      m_usp = '0;
      m_ksp = 32'd6143;
      m_phase = 0;
      m_entering = 1'b0;
      m_kernel = 1'b0;
      m_priv = 1'b0;
      m_busy = 1'b0;
      e_rda = '0; e_rdb = '0; e_mo = '0;
      e_cpc = 32'd1;
      e_csp = 32'd8191;
   endtask

   task automatic m_step();
      logic [31:0] pre [16];
      logic [31:0] src [16];
      pre = m_r;
      if (m_phase == 2) begin
         m_r[14] = m_entering ? m_ksp : m_usp;
         m_priv  = m_entering;
         m_phase = 1;
      end else if (m_phase == 1) begin
         m_phase = 0;
         m_busy  = 1'b0;
      end else if (en) begin
         case (ctl)
            3'd1: if (rd < 4'd14) m_r[rd] = alu;
            3'd3: begin
               if (rd < 4'd14) m_r[rd] = mem;
               m_r[14] = nsp;
            end
            3'd4: if (!m_kernel) begin
               m_usp = m_r[14];
               m_r[13] = m_r[15];
               m_phase = 2; m_entering = 1'b1; m_kernel = 1'b1; m_busy = 1'b1;
            end
            3'd5: if (m_kernel) begin
               m_ksp = m_r[14];
               m_phase = 2; m_entering = 1'b0; m_kernel = 1'b0; m_busy = 1'b1;
            end
            3'd6: if (rd != 4'd15) m_r[rd] = {28'd0, spec};
            default: m_r[14] = nsp;
         endcase
         m_r[15] = br ? alu : npc;
      end
`ifdef REGBANK_BYPASS_EN
      src = m_r;
`else
      src = pre;
`endif
      e_rda = src[ra];
      e_rdb = src[rb];
      e_mo  = src[rd];
      e_cpc = src[15];
      e_csp = src[14];
   endtask

   task automatic check_outs();
      chk("read_data_A", rda, e_rda);
      chk("read_data_B", rdb, e_rdb);
      chk("memory_output", mo, e_mo);
      chk("current_PC", cpc, e_cpc);
      chk("current_SP", csp, e_csp);
      chk("privileged", {31'd0, priv}, {31'd0, m_priv});
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
   endtask

   task automatic cyc();
      m_step();
      @(posedge clk);
      #1;
      check_outs();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      en  = 1'b0;
      repeat (2) @(posedge clk);
      m_reset();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_outs();
   endtask

   initial begin
      m_reset();
      do_reset();
      chk("rst_current_PC", cpc, 32'd1);
      chk("rst_current_SP", csp, 32'd8191);
      ra = 4'd0;
      cyc();
      chk("rst_R0", rda, 32'd8192);

      // ALU write, then read back
      en = 1'b1; ctl = 3'd1; rd = 4'd3; alu = 32'hDEADBEEF; ra = 4'd3; npc = 32'd2; br = 1'b0;
      cyc();
      en = 1'b0;
      cyc();
      chk("alu_write_R3", rda, 32'hDEADBEEF);

      // ALU write to PC is dropped; PC follows new_PC
      en = 1'b1; ctl = 3'd1; rd = 4'd15; alu = 32'd5; npc = 32'd77;
      cyc();
      en = 1'b0;
      cyc();
      chk("alu_pc_dropped", cpc, 32'd77);

      // SP=8000, PC=40, then enter kernel
      en = 1'b1; ctl = 3'd0; nsp = 32'd8000; npc = 32'd40; rd = 4'd0;
      cyc();
      ctl = 3'd4; npc = 32'd44; ra = 4'd13;
      cyc();
      chk("enter_busy1", {31'd0, busy}, 32'd1);
      cyc();
      chk("enter_busy2", {31'd0, busy}, 32'd1);
      cyc();
      chk("enter_done_busy", {31'd0, busy}, 32'd0);
      chk("enter_priv", {31'd0, priv}, 32'd1);
      chk("enter_kernel_sp", csp, 32'd6143);
      chk("enter_lr", rda, 32'd40);
      npc = 32'd50;
      cyc();
      chk("enter_again_noop", {31'd0, busy}, 32'd0);

      // Kernel SP to 6000, exit, re-enter
      ctl = 3'd0; nsp = 32'd6000;
      cyc();
      ctl = 3'd5;
      repeat (3) cyc();
      chk("exit_user_sp", csp, 32'd8000);
      chk("exit_priv", {31'd0, priv}, 32'd0);
      chk("exit_busy", {31'd0, busy}, 32'd0);
      ctl = 3'd4;
      repeat (3) cyc();
      chk("reenter_kernel_sp", csp, 32'd6000);
      ctl = 3'd5;
      repeat (3) cyc();

      // Special-register copy and branch with enable low
      en = 1'b1; ctl = 3'd6; spec = 4'hA; rd = 4'd2; npc = 32'd90; br = 1'b0;
      cyc();
      en = 1'b0; br = 1'b1; alu = 32'd123; ra = 4'd2;
      cyc();
      cyc();
      chk("cpxr_R2", rda, 32'h0000000A);
      chk("disabled_branch_pc", cpc, 32'd90);

      // Random ops against the model
      for (int i = 0; i < 400; i++) begin
         en   = ($urandom_range(0, 3) != 0);
         ctl  = 3'($urandom_range(0, 7));
         ra   = 4'($urandom);
         rb   = 4'($urandom);
         rd   = 4'($urandom);
         alu  = $urandom;
         mem  = $urandom;
         nsp  = $urandom;
         npc  = $urandom;
         br   = 1'($urandom_range(0, 1));
         spec = 4'($urandom);
         cyc();
      end

      // Reset asserted in ENTERING takes effect before the next edge
      do_reset();
      en = 1'b1; ctl = 3'd4; br = 1'b0; npc = 32'd12;
      cyc();
      chk("mid_switch_busy_before", {31'd0, busy}, 32'd1);
      en = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      chk("mid_switch_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_switch_rst_priv", {31'd0, priv}, 32'd0);
      chk("mid_switch_rst_sp", csp, 32'd8191);
      chk("mid_switch_rst_pc", cpc, 32'd1);
      m_reset();
      @(negedge clk);
      rst = 1'b0;
      ra = 4'd0; rb = 4'd14;
      repeat (4) cyc();
      chk("post_rst_R0", rda, 32'd8192);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
